// File: rtl/spike_rate_decoder_pkg.sv
// Shared types and sizing for the spike rate decoder.
// Window length is 2^(window_sel + WIN_BASE_LOG2) cycles.
package spike_decoder_pkg;

  typedef enum logic {
    IDLE,
    COUNT
  } state_t;

  localparam int CNT_W         = 8;
  localparam int WCNT_W        = 11;
  localparam int WIN_BASE_LOG2 = 4;
  localparam int ISI_MAX       = 255;

  function automatic logic [WCNT_W-1:0] win_last(
    input logic [2:0] sel
  );
    int w;
    w = 1 << (int'(sel) + WIN_BASE_LOG2);
    return WCNT_W'(w - 1);
  endfunction

endpackage

// File: rtl/spike_rate_decoder_if.sv
// Spike input, control and decoded-rate outputs.
// master drives stimulus, slave is the decoder.
interface spike_rate_decoder_if;
  import spike_decoder_pkg::*;

  logic              spike_in;
  logic              ena;
  logic [2:0]        window_sel;
  logic [CNT_W-1:0]  count_out;
  logic              count_valid;
  logic              overflow;
  logic [7:0]        isi_out;
  logic              isi_valid;

  modport master (
    output spike_in,
    output ena,
    output window_sel,
    input  count_out,
    input  count_valid,
    input  overflow,
    input  isi_out,
    input  isi_valid
  );

  modport slave (
    input  spike_in,
    input  ena,
    input  window_sel,
    output count_out,
    output count_valid,
    output overflow,
    output isi_out,
    output isi_valid
  );

endinterface

// File: rtl/spike_rate_decoder_edge.sv
// Rising-edge detector for the spike train.
// A held-high input produces a single rise.
module spike_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic in,
  output logic rise
);

  logic prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev <= 1'b0;
    else        prev <= in;
  end

  assign rise = in & ~prev;

endmodule

// File: rtl/spike_rate_decoder.sv
// Counts spikes over back-to-back power-of-two windows
// and measures the interval between consecutive spikes.
module spike_rate_decoder
  import spike_decoder_pkg::*;
(
  input logic                 clk,
  input logic                 rst_n,
  spike_rate_decoder_if.slave io
);

  logic              rise;
  state_t            state;
  logic [WCNT_W-1:0] wcnt;
  logic [WCNT_W-1:0] wlast;
  logic [CNT_W-1:0]  spk;
  logic              sat;
  logic [7:0]        isi_cnt;
  logic              armed;

  logic              spk_full;
  logic [CNT_W-1:0]  spk_nxt;
  logic              sat_nxt;
  logic              isi_full;

  spike_edge_detect u_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .in    (io.spike_in),
    .rise  (rise)
  );

  assign spk_full = (spk == {CNT_W{1'b1}});
  assign spk_nxt  = (rise && !spk_full) ? spk + 1'b1 : spk;
  // sat remembers that a 256th spike arrived this window
  assign sat_nxt  = sat | (rise & spk_full);
  assign isi_full = (isi_cnt == 8'(ISI_MAX));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      wcnt           <= '0;
      wlast          <= '0;
      spk            <= '0;
      sat            <= 1'b0;
      isi_cnt        <= '0;
      armed          <= 1'b0;
      io.count_out   <= '0;
      io.count_valid <= 1'b0;
      io.overflow    <= 1'b0;
      io.isi_out     <= '0;
      io.isi_valid   <= 1'b0;
    end else begin
      io.count_valid <= 1'b0;
      io.isi_valid   <= 1'b0;
      unique case (state)
        IDLE: begin
          wcnt    <= '0;
          spk     <= '0;
          sat     <= 1'b0;
          isi_cnt <= '0;
          armed   <= 1'b0;
          if (io.ena) begin
            state <= COUNT;
            wlast <= win_last(io.window_sel);
          end
        end
        COUNT: begin
          if (!io.ena) begin
            state <= IDLE;
          end else begin
            if (wcnt == wlast) begin
              io.count_out   <= spk_nxt;
              io.overflow    <= sat_nxt;
              io.count_valid <= 1'b1;
              wcnt           <= '0;
              spk            <= '0;
              sat            <= 1'b0;
              wlast          <= win_last(io.window_sel);
            end else begin
              wcnt <= wcnt + 1'b1;
              spk  <= spk_nxt;
              sat  <= sat_nxt;
            end
            if (rise) begin
              if (armed) begin
                io.isi_out   <= isi_full ? isi_cnt
                                         : isi_cnt + 8'd1;
                io.isi_valid <= 1'b1;
              end
              armed   <= 1'b1;
              isi_cnt <= '0;
            end else if (!isi_full) begin
              isi_cnt <= isi_cnt + 8'd1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Randomized and scenario stimulus for spike_rate_decoder,
// checked cycle by cycle against a timestamp-based model.
module tb_spike_rate_decoder;

  logic clk;
  logic rst_n;

  spike_rate_decoder_if io ();

  spike_rate_decoder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (io)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total;
  int bad;

  int m_prev;
  int m_active;
  int m_pos;
  int m_wlen;
  int m_cnt;
  int m_armed;
  int m_last;
  int m_cyc;

  int exp_count;
  int exp_cv;
  int exp_ovf;
  int exp_isi;
  int exp_iv;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)",
               tag, obs, exp, m_cyc);
    end
  endtask

  task automatic check_outputs();
    chk("count_out",   int'(io.count_out),   exp_count);
    chk("count_valid", int'(io.count_valid), exp_cv);
    chk("overflow",    int'(io.overflow),    exp_ovf);
    chk("isi_out",     int'(io.isi_out),     exp_isi);
    chk("isi_valid",   int'(io.isi_valid),   exp_iv);
  endtask

  task automatic model_reset();
    m_prev    = 0;
    m_active  = 0;
    m_pos     = 0;
    m_wlen    = 16;
    m_cnt     = 0;
    m_armed   = 0;
    m_last    = 0;
    exp_count = 0;
    exp_cv    = 0;
    exp_ovf   = 0;
    exp_isi   = 0;
    exp_iv    = 0;
  endtask

  // What the next clock edge should produce for these inputs.
  task automatic model_step(input int s, input int e, input int sel);
    int rise;
    rise   = (s != 0 && m_prev == 0) ? 1 : 0;
    m_prev = s;
    exp_cv = 0;
    exp_iv = 0;
    if (m_active == 0) begin
      if (e != 0) begin
        m_active = 1;
        m_pos    = 0;
        m_wlen   = 2 ** (sel + 4);
        m_cnt    = 0;
        m_armed  = 0;
      end
    end else if (e == 0) begin
      m_active = 0;
    end else begin
      if (rise != 0) begin
        m_cnt++;
        if (m_armed != 0) begin
          exp_isi = (m_cyc - m_last > 255) ? 255 : m_cyc - m_last;
          exp_iv  = 1;
        end
        m_armed = 1;
        m_last  = m_cyc;
      end
      if (m_pos == m_wlen - 1) begin
        exp_count = (m_cnt > 255) ? 255 : m_cnt;
        exp_ovf   = (m_cnt > 255) ? 1 : 0;
        exp_cv    = 1;
        m_pos     = 0;
        m_cnt     = 0;
        m_wlen    = 2 ** (sel + 4);
      end else begin
        m_pos++;
      end
    end
    m_cyc++;
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic step(input int s, input int e, input int sel);
    io.spike_in   = (s != 0);
    io.ena        = (e != 0);
    io.window_sel = 3'(sel);
    model_step(s, e, sel);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic pulse_reset();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_count_out",   int'(io.count_out),   0);
    chk("rst_count_valid", int'(io.count_valid), 0);
    chk("rst_overflow",    int'(io.overflow),    0);
    chk("rst_isi_out",     int'(io.isi_out),     0);
    chk("rst_isi_valid",   int'(io.isi_valid),   0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int sel;
    int p;
    int n;
    total         = 0;
    bad           = 0;
    m_cyc         = 0;
    rst_n         = 1'b0;
    io.spike_in   = 1'b0;
    io.ena        = 1'b0;
    io.window_sel = 3'd0;
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs();
    rst_n = 1'b1;

    // five spikes in a 16-cycle window
    for (int i = 0; i < 40; i++)
      step(((i % 3) == 1 && i < 16) ? 1 : 0, 1, 0);

    // 128 spikes in 256, then a saturating 2048 window
    for (int i = 0; i < 600; i++) step((i % 2) == 0 ? 1 : 0, 1, 4);
    for (int i = 0; i < 2400; i++)
      step(((i % 2) == 0 && i < 1400) ? 1 : 0, 1, 7);

    // spike exactly on the last window cycle
    for (int i = 0; i < 200; i++)
      step((m_active != 0 && m_pos == m_wlen - 1) ? 1 : 0, 1, 1);

    // ISI of 10, then a saturated 300
    for (int i = 0; i < 400; i++)
      step((i == 5 || i == 15 || i == 315) ? 1 : 0, 1, 3);

    // drop ena mid-window after three spikes
    step(0, 0, 0);
    step(0, 0, 0);
    for (int i = 0; i < 9; i++)
      step((i == 2 || i == 4 || i == 6) ? 1 : 0, 1, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0);
    for (int i = 0; i < 40; i++) step((i % 4) == 1 ? 1 : 0, 1, 0);

    // reset mid-window while spike held high
    for (int i = 0; i < 10; i++) step((i % 3) == 0 ? 1 : 0, 1, 2);
    io.spike_in = 1'b1;
    pulse_reset();
    for (int i = 0; i < 20; i++) step(1, 1, 2);
    for (int i = 0; i < 100; i++) step(0, 1, 2);

    // random segments
    for (int seg = 0; seg < 8; seg++) begin
      sel = int'($urandom_range(0, 5));
      p   = int'($urandom_range(5, 70));
      n   = int'($urandom_range(300, 2500));
      for (int i = 0; i < n; i++) begin
        if (($urandom % 2500) == 0) begin
          pulse_reset();
        end else begin
          if (($urandom % 200) == 0) sel = int'($urandom_range(0, 5));
          step((($urandom % 100) < p) ? 1 : 0,
               (($urandom % 400) != 0) ? 1 : 0, sel);
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
